// File: rtl/bf2_sdf_stage_if.sv
// Stream bundle around one radix-2 SDF butterfly stage: sample input side,
// result output side, and the frame/alert/error sidebands.
interface bf2_sdf_stage_if #(
    parameter int WIDTH = 12,
    parameter int LANES = 2
);
    logic                              din_valid;
    logic                              din_ready;
    logic [LANES-1:0][WIDTH-1:0]       din_R;
    logic [LANES-1:0][WIDTH-1:0]       din_Q;
    logic                              alert_in;

    logic                              dout_valid;
    logic [LANES-1:0][WIDTH:0]         dout_R;
    logic [LANES-1:0][WIDTH:0]         dout_Q;
    logic                              dout_last;
    logic                              alert_out;
    logic                              err;

    // master feeds samples and consumes results; the stage itself is the slave
    modport master (
        output din_valid, din_R, din_Q, alert_in,
        input  din_ready, dout_valid, dout_R, dout_Q, dout_last, alert_out, err
    );

    modport slave (
        input  din_valid, din_R, din_Q, alert_in,
        output din_ready, dout_valid, dout_R, dout_Q, dout_last, alert_out, err
    );
endinterface

// File: rtl/bf2_sdf_stage.sv
// Radix-2 DIF single-delay-feedback butterfly stage: partners arrive DEPTH
// cycles apart, sums leave immediately, differences are parked and drained.
module bf2_sdf_stage #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4,
    parameter int LANES = 2,
    parameter int TW_EN = 1
) (
    input  logic             clk,
    input  logic             rstn,
    bf2_sdf_stage_if.slave   bus
);
    localparam int CW = $clog2(DEPTH);
    localparam int OW = WIDTH + 1;

    typedef enum logic [1:0] {IDLE, FILL, CALC, DRAIN} state_t;

    state_t                   state;
    logic [CW-1:0]            cnt;
    logic                     pend;
    logic                     alert_seen_unused;

    logic [OW-1:0]            dly_R [DEPTH][LANES];
    logic [OW-1:0]            dly_Q [DEPTH][LANES];

    logic                     accept;
    logic                     last_idx;
    logic                     rot;
    logic [LANES-1:0][OW-1:0] rd_R, rd_Q;
    logic [LANES-1:0][OW-1:0] y_R, y_Q;
    logic [LANES-1:0][OW-1:0] add_R, add_Q;
    logic [LANES-1:0][OW-1:0] sub_R, sub_Q;
    logic [LANES-1:0][OW-1:0] wr_R, wr_Q;

    // The delay line holds raw samples during FILL and differences after CALC,
    // so a single read port at cnt serves both the sum and the drained sub.
    always_comb begin
        accept   = bus.din_valid & bus.din_ready;
        last_idx = (cnt == CW'(DEPTH - 1));
        rot      = (TW_EN != 0) && cnt[CW-1];
        for (int l = 0; l < LANES; l++) begin
            rd_R[l]  = dly_R[cnt][l];
            rd_Q[l]  = dly_Q[cnt][l];
            y_R[l]   = {bus.din_R[l][WIDTH-1], bus.din_R[l]};
            y_Q[l]   = {bus.din_Q[l][WIDTH-1], bus.din_Q[l]};
            add_R[l] = rd_R[l] + y_R[l];
            add_Q[l] = rd_Q[l] + y_Q[l];
            sub_R[l] = rot ? rd_Q[l] : rd_R[l];
            sub_Q[l] = rot ? -rd_R[l] : rd_Q[l];
            wr_R[l]  = (state == CALC) ? rd_R[l] - y_R[l] : y_R[l];
            wr_Q[l]  = (state == CALC) ? rd_Q[l] - y_Q[l] : y_Q[l];
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int l = 0; l < LANES; l++) begin
                dly_R[cnt][l] <= wr_R[l];
                dly_Q[cnt][l] <= wr_Q[l];
            end
        end
    end

    // A missing sample mid-frame aborts the frame; any subs still owed from
    // the previous frame are drained from where the abort happened.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state             <= IDLE;
            cnt               <= '0;
            pend              <= 1'b0;
            alert_seen_unused <= 1'b0;
            bus.din_ready     <= 1'b1;
            bus.dout_valid    <= 1'b0;
            bus.dout_R        <= '0;
            bus.dout_Q        <= '0;
            bus.dout_last     <= 1'b0;
            bus.alert_out     <= 1'b0;
            bus.err           <= 1'b0;
        end else begin
            bus.dout_valid    <= 1'b0;
            bus.dout_last     <= 1'b0;
            bus.alert_out     <= 1'b0;
            bus.err           <= 1'b0;
            alert_seen_unused <= bus.alert_in;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= FILL;
                        cnt   <= CW'(1);
                    end
                end
                FILL: begin
                    if (accept) begin
                        if (pend) begin
                            bus.dout_valid <= 1'b1;
                            bus.dout_R     <= sub_R;
                            bus.dout_Q     <= sub_Q;
                            bus.dout_last  <= last_idx;
                        end
                        if (last_idx) begin
                            state <= CALC;
                            cnt   <= '0;
                            pend  <= 1'b0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end else begin
                        bus.err <= (cnt != '0);
                        if (pend) begin
                            bus.dout_valid <= 1'b1;
                            bus.dout_R     <= sub_R;
                            bus.dout_Q     <= sub_Q;
                            bus.dout_last  <= last_idx;
                            if (last_idx) begin
                                state <= IDLE;
                                cnt   <= '0;
                                pend  <= 1'b0;
                            end else begin
                                state         <= DRAIN;
                                cnt           <= cnt + CW'(1);
                                bus.din_ready <= 1'b0;
                            end
                        end else begin
                            state <= IDLE;
                            cnt   <= '0;
                        end
                    end
                end
                CALC: begin
                    if (accept) begin
                        bus.dout_valid <= 1'b1;
                        bus.dout_R     <= add_R;
                        bus.dout_Q     <= add_Q;
                        bus.alert_out  <= (cnt == '0);
                        if (last_idx) begin
                            state <= FILL;
                            cnt   <= '0;
                            pend  <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end else begin
                        bus.err <= 1'b1;
                        state   <= IDLE;
                        cnt     <= '0;
                        pend    <= 1'b0;
                    end
                end
                DRAIN: begin
                    bus.dout_valid <= 1'b1;
                    bus.dout_R     <= sub_R;
                    bus.dout_Q     <= sub_Q;
                    bus.dout_last  <= last_idx;
                    if (last_idx) begin
                        state         <= IDLE;
                        cnt           <= '0;
                        pend          <= 1'b0;
                        bus.din_ready <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state         <= IDLE;
                    cnt           <= '0;
                    pend          <= 1'b0;
                    bus.din_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bf2_sdf_stage.sv
// Directed bench for bf2_sdf_stage: one rotating stage and one TW_EN=0 stage
// share the same stimulus; expected results are hand-derived per cycle.
module tb_bf2_sdf_stage;
    localparam int WIDTH = 12;
    localparam int DEPTH = 4;
    localparam int LANES = 2;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    bf2_sdf_stage_if #(.WIDTH(WIDTH), .LANES(LANES)) bus ();
    bf2_sdf_stage_if #(.WIDTH(WIDTH), .LANES(LANES)) bus0 ();

    bf2_sdf_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LANES(LANES), .TW_EN(1)) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    bf2_sdf_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LANES(LANES), .TW_EN(0)) dut0 (
        .clk (clk),
        .rstn(rstn),
        .bus (bus0)
    );

    assign bus0.din_valid = bus.din_valid;
    assign bus0.din_R     = bus.din_R;
    assign bus0.din_Q     = bus.din_Q;
    assign bus0.alert_in  = bus.alert_in;

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int r0, input int q0, input int r1, input int q1,
                         input logic a);
        bus.din_valid = v;
        bus.din_R[0]  = 12'(r0);
        bus.din_Q[0]  = 12'(q0);
        bus.din_R[1]  = 12'(r1);
        bus.din_Q[1]  = 12'(q1);
        bus.alert_in  = a;
    endtask

    function automatic logic [51:0] pack4(input int r0, input int q0, input int r1, input int q1);
        return {13'(r0), 13'(q0), 13'(r1), 13'(q1)};
    endfunction

    function automatic logic [51:0] got1();
        return {bus.dout_R[0], bus.dout_Q[0], bus.dout_R[1], bus.dout_Q[1]};
    endfunction

    function automatic logic [51:0] got0();
        return {bus0.dout_R[0], bus0.dout_Q[0], bus0.dout_R[1], bus0.dout_Q[1]};
    endfunction

    task automatic test_reset();
        rstn = 1'b0;
        drive(1'b0, 0, 0, 0, 0, 1'b0);
        step();
        checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b expected 0", bus.dout_valid); end
        checks++; if (bus.din_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b expected 1", bus.din_ready); end
        checks++; if ({bus.dout_last, bus.alert_out, bus.err} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags got %b expected 000", {bus.dout_last, bus.alert_out, bus.err}); end
        checks++; if (got1() !== 52'd0) begin errors++; $display("[TB] FAIL reset_data got %h expected 0", got1()); end
        rstn = 1'b1;
        step();
        checks++; if (bus.dout_valid !== 1'b0 || bus.din_ready !== 1'b1) begin errors++; $display("[TB] FAIL idle_after_reset got valid=%b ready=%b expected valid=0 ready=1", bus.dout_valid, bus.din_ready); end
    endtask

    task automatic test_single_frame();
        logic        ev, er;
        logic [51:0] e1, e0;
        int          k;
        for (int c = 1; c <= 13; c++) begin
            if (c <= 8) drive(1'b1, c, 0, 0, c, c == 1);
            else        drive(1'b0, 0, 0, 0, 0, 1'b0);
            step();
            ev = (c >= 5 && c <= 12);
            er = !(c >= 9 && c <= 11);
            checks++; if (bus.dout_valid !== ev) begin errors++; $display("[TB] FAIL single_valid c=%0d got %b expected %b", c, bus.dout_valid, ev); end
            checks++; if (bus0.dout_valid !== ev) begin errors++; $display("[TB] FAIL single_valid_tw0 c=%0d got %b expected %b", c, bus0.dout_valid, ev); end
            checks++; if (bus.din_ready !== er) begin errors++; $display("[TB] FAIL single_ready c=%0d got %b expected %b", c, bus.din_ready, er); end
            checks++; if (bus.err !== 1'b0 || bus0.err !== 1'b0) begin errors++; $display("[TB] FAIL single_err c=%0d got %b/%b expected 0/0", c, bus.err, bus0.err); end
            checks++; if (bus.dout_last !== (c == 12) || bus0.dout_last !== (c == 12)) begin errors++; $display("[TB] FAIL single_last c=%0d got %b/%b expected %b", c, bus.dout_last, bus0.dout_last, c == 12); end
            checks++; if (bus.alert_out !== (c == 5) || bus0.alert_out !== (c == 5)) begin errors++; $display("[TB] FAIL single_alert c=%0d got %b/%b expected %b", c, bus.alert_out, bus0.alert_out, c == 5); end
            if (ev) begin
                if (c <= 8) begin
                    k  = 2 * (c - 5) + 6;
                    e1 = pack4(k, 0, 0, k);
                    e0 = e1;
                end else if (c <= 10) begin
                    e1 = pack4(-4, 0, 0, -4);
                    e0 = e1;
                end else begin
                    e1 = pack4(0, 4, -4, 0);
                    e0 = pack4(-4, 0, 0, -4);
                end
                checks++; if (got1() !== e1) begin errors++; $display("[TB] FAIL single_data c=%0d got %h expected %h", c, got1(), e1); end
                checks++; if (got0() !== e0) begin errors++; $display("[TB] FAIL single_data_tw0 c=%0d got %h expected %h", c, got0(), e0); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic        ev, er;
        logic [51:0] e1;
        int          idx, p, n, d;
        for (int c = 1; c <= 21; c++) begin
            idx = c - 1;
            if (idx < 8)       drive(1'b1, idx + 1, 0, 0, 0, idx == 0);
            else if (idx < 16) drive(1'b1, 10 * (idx - 7), 0, 0, 0, idx == 8);
            else               drive(1'b0, 0, 0, 0, 0, 1'b0);
            step();
            ev = (c >= 5 && c <= 20);
            er = !(c >= 17 && c <= 19);
            p  = (c - 5) % 8;
            checks++; if (bus.dout_valid !== ev) begin errors++; $display("[TB] FAIL b2b_valid c=%0d got %b expected %b", c, bus.dout_valid, ev); end
            checks++; if (bus.din_ready !== er) begin errors++; $display("[TB] FAIL b2b_ready c=%0d got %b expected %b", c, bus.din_ready, er); end
            checks++; if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL b2b_err c=%0d got %b expected 0", c, bus.err); end
            checks++; if (bus.dout_last !== (c == 12 || c == 20)) begin errors++; $display("[TB] FAIL b2b_last c=%0d got %b expected %b", c, bus.dout_last, c == 12 || c == 20); end
            checks++; if (bus.alert_out !== (c == 5 || c == 13)) begin errors++; $display("[TB] FAIL b2b_alert c=%0d got %b expected %b", c, bus.alert_out, c == 5 || c == 13); end
            if (ev) begin
                if (p < 4) begin
                    e1 = (c < 13) ? pack4(6 + 2 * p, 0, 0, 0) : pack4(60 + 20 * p, 0, 0, 0);
                end else begin
                    n  = p - 4;
                    d  = (c < 13) ? -4 : -40;
                    e1 = (n < 2) ? pack4(d, 0, 0, 0) : pack4(0, -d, 0, 0);
                end
                checks++; if (got1() !== e1) begin errors++; $display("[TB] FAIL b2b_data c=%0d got %h expected %h", c, got1(), e1); end
            end
        end
    endtask

    task automatic test_extremes();
        logic        ev;
        logic [51:0] e1;
        for (int c = 1; c <= 13; c++) begin
            if (c <= 4)      drive(1'b1, -2048, 0, 2047, 0, c == 1);
            else if (c <= 8) drive(1'b1, 2047, 0, -2048, 0, 1'b0);
            else             drive(1'b0, 0, 0, 0, 0, 1'b0);
            step();
            ev = (c >= 5 && c <= 12);
            checks++; if (bus.dout_valid !== ev) begin errors++; $display("[TB] FAIL ext_valid c=%0d got %b expected %b", c, bus.dout_valid, ev); end
            checks++; if (bus.dout_last !== (c == 12)) begin errors++; $display("[TB] FAIL ext_last c=%0d got %b expected %b", c, bus.dout_last, c == 12); end
            if (ev) begin
                if (c <= 8)       e1 = pack4(-1, 0, -1, 0);
                else if (c <= 10) e1 = pack4(-4095, 0, 4095, 0);
                else              e1 = pack4(0, 4095, 0, -4095);
                checks++; if (got1() !== e1) begin errors++; $display("[TB] FAIL ext_data c=%0d got %h expected %h", c, got1(), e1); end
            end
        end
    endtask

    task automatic test_calc_gap();
        logic        ev;
        logic [51:0] e1;
        for (int c = 1; c <= 12; c++) begin
            if (c <= 6) drive(1'b1, 99 + c, 0, 0, 0, c == 1);
            else        drive(1'b0, 0, 0, 0, 0, 1'b0);
            step();
            ev = (c == 5 || c == 6);
            checks++; if (bus.dout_valid !== ev) begin errors++; $display("[TB] FAIL gap_valid c=%0d got %b expected %b", c, bus.dout_valid, ev); end
            checks++; if (bus.err !== (c == 7)) begin errors++; $display("[TB] FAIL gap_err c=%0d got %b expected %b", c, bus.err, c == 7); end
            checks++; if (bus.dout_last !== 1'b0) begin errors++; $display("[TB] FAIL gap_last c=%0d got %b expected 0", c, bus.dout_last); end
            checks++; if (bus.din_ready !== 1'b1) begin errors++; $display("[TB] FAIL gap_ready c=%0d got %b expected 1", c, bus.din_ready); end
            if (ev) begin
                e1 = pack4(204 + 2 * (c - 5), 0, 0, 0);
                checks++; if (got1() !== e1) begin errors++; $display("[TB] FAIL gap_data c=%0d got %h expected %h", c, got1(), e1); end
            end
        end
    endtask

    task automatic test_reset_midframe();
        for (int c = 1; c <= 10; c++) begin
            drive(1'b1, c, 0, 0, 0, c == 1 || c == 9);
            step();
        end
        checks++; if (bus.dout_valid !== 1'b1 || got1() !== pack4(-4, 0, 0, 0)) begin errors++; $display("[TB] FAIL midrst_pre got valid=%b data=%h expected valid=1 data=%h", bus.dout_valid, got1(), pack4(-4, 0, 0, 0)); end
        rstn = 1'b0;
        #1;
        checks++; if (bus.dout_valid !== 1'b0 || bus0.dout_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_valid got %b/%b expected 0/0", bus.dout_valid, bus0.dout_valid); end
        checks++; if (bus.din_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_ready got %b expected 1", bus.din_ready); end
        checks++; if (got1() !== 52'd0 || got0() !== 52'd0) begin errors++; $display("[TB] FAIL midrst_data got %h/%h expected 0", got1(), got0()); end
        checks++; if ({bus.dout_last, bus.alert_out, bus.err} !== 3'b000) begin errors++; $display("[TB] FAIL midrst_flags got %b expected 000", {bus.dout_last, bus.alert_out, bus.err}); end
        drive(1'b0, 0, 0, 0, 0, 1'b0);
        step();
        rstn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++; if (bus.dout_valid !== 1'b0 || bus.din_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_idle c=%0d got valid=%b ready=%b expected valid=0 ready=1", c, bus.dout_valid, bus.din_ready); end
        end
    endtask

    initial begin
        $display("[TB] starting bf2_sdf_stage bench");
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_extremes();
        test_calc_gap();
        test_single_frame();
        test_reset_midframe();
        test_single_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
